// File: rtl/yacht_pkg.sv
// Shared constants, state encoding and the die-draw helper for the yacht dice engine.
package yacht_pkg;

  localparam int DIE_W    = 3;
  localparam int NUM_DICE = 5;

  localparam logic [3:0] CAT_ONES       = 4'd0;
  localparam logic [3:0] CAT_TWOS       = 4'd1;
  localparam logic [3:0] CAT_THREES     = 4'd2;
  localparam logic [3:0] CAT_FOURS      = 4'd3;
  localparam logic [3:0] CAT_FIVES      = 4'd4;
  localparam logic [3:0] CAT_SIXES      = 4'd5;
  localparam logic [3:0] CAT_CHOICE     = 4'd6;
  localparam logic [3:0] CAT_FOUR_KIND  = 4'd7;
  localparam logic [3:0] CAT_FULL_HOUSE = 4'd8;
  localparam logic [3:0] CAT_SSTRAIGHT  = 4'd9;
  localparam logic [3:0] CAT_LSTRAIGHT  = 4'd10;
  localparam logic [3:0] CAT_YACHT      = 4'd11;

  localparam logic [7:0] SCORE_SSTRAIGHT = 8'd15;
  localparam logic [7:0] SCORE_LSTRAIGHT = 8'd30;
  localparam logic [7:0] SCORE_YACHT     = 8'd50;

  typedef enum logic [1:0] {ST_IDLE, ST_SHAKE, ST_COUNT, ST_EVAL} state_t;

  // Scales a uniform byte onto 1..6 without a divider.
  function automatic logic [DIE_W-1:0] draw_die(input logic [7:0] b);
    logic [10:0] p;
    p = 11'(b) * 11'd6;
    return p[10:8] + 3'd1;
  endfunction

endpackage

// File: rtl/yacht_lfsr32.sv
// Free-running 32-bit Galois LFSR (x^32+x^22+x^2+x+1); exposes the low 28 bits used for die draws.
module yacht_lfsr32 #(
  parameter logic [31:0] SEED = 32'hACE1_2025
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [27:0] bits
);

  localparam logic [31:0] INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic [31:0] state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= (state >> 1) ^ (state[0] ? TAPS : 32'd0);
  end

  assign bits = state[27:0];

endmodule

// File: rtl/yacht_dice_engine.sv
// Yacht dice roller and category scorer: shake, sequential face histogram, then scoring.
// Optional YACHT_DICE_FORCE_EN adds force_load/force_dice to load dice directly.
module yacht_dice_engine
  import yacht_pkg::*;
#(
  parameter int          SHAKE_CYCLES = 8,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_2025
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        roll_trigger,
  input  logic        new_turn,
  input  logic [4:0]  hold_tgl,
  input  logic [3:0]  category_idx,
  output logic [14:0] dice,
  output logic [4:0]  hold_mask,
  output logic        busy,
  output logic [7:0]  calc_score,
  output logic        score_valid
`ifdef YACHT_DICE_FORCE_EN
  ,
  input  logic        force_load,
  input  logic [14:0] force_dice
`endif
);

  localparam logic [14:0] DICE_RESET = 15'h1249;

  state_t          state;
  logic [7:0]      shake_left;
  logic [2:0]      count_k;
  logic [7:0][2:0] cnt;
  logic [4:0]      sum;
  logic [3:0]      cat_reg;
  logic            rolled;
  logic [27:0]     rnd;
  logic [2:0]      cur_die;

  yacht_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .bits    (rnd)
  );

  assign cur_die = dice[DIE_W*int'(count_k) +: DIE_W];

  function automatic logic [7:0] score_of(input logic [3:0] idx, input logic [7:0][2:0] c,
                                          input logic [4:0] s);
    logic [2:0] face;
    logic [6:1] present;
    logic       has2, has3, has4, has5, ss, ls;
    logic [7:0] score;
    face = idx[2:0] + 3'd1;
    has2 = 1'b0;
    has3 = 1'b0;
    has4 = 1'b0;
    has5 = 1'b0;
    for (int f = 1; f <= 6; f++) begin
      present[f] = (c[f] != 3'd0);
      has2 = has2 | (c[f] == 3'd2);
      has3 = has3 | (c[f] == 3'd3);
      has4 = has4 | (c[f] >= 3'd4);
      has5 = has5 | (c[f] == 3'd5);
    end
    ss = (&present[4:1]) | (&present[5:2]) | (&present[6:3]);
    ls = (&present[5:1]) | (&present[6:2]);
    case (idx)
      CAT_ONES, CAT_TWOS, CAT_THREES,
      CAT_FOURS, CAT_FIVES, CAT_SIXES: score = 8'(c[face]) * 8'(face);
      CAT_CHOICE:     score = 8'(s);
      CAT_FOUR_KIND:  score = has4 ? 8'(s) : 8'd0;
      // A yacht has no pair, so it never counts as a full house.
      CAT_FULL_HOUSE: score = (has3 && has2) ? 8'(s) : 8'd0;
      CAT_SSTRAIGHT:  score = ss ? SCORE_SSTRAIGHT : 8'd0;
      CAT_LSTRAIGHT:  score = ls ? SCORE_LSTRAIGHT : 8'd0;
      CAT_YACHT:      score = has5 ? SCORE_YACHT : 8'd0;
      default:        score = 8'd0;
    endcase
    return score;
  endfunction

`ifdef YACHT_DICE_FORCE_EN
  function automatic logic [2:0] clean_face(input logic [2:0] f);
    return (f == 3'd0 || f == 3'd7) ? 3'd1 : f;
  endfunction
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      shake_left  <= 8'd0;
      count_k     <= 3'd0;
      cnt         <= '0;
      sum         <= 5'd0;
      cat_reg     <= 4'd0;
      rolled      <= 1'b0;
      dice        <= DICE_RESET;
      hold_mask   <= 5'd0;
      busy        <= 1'b0;
      calc_score  <= 8'd0;
      score_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          hold_mask <= new_turn ? 5'd0 : (hold_mask ^ hold_tgl);
          if (roll_trigger) begin
            state       <= ST_SHAKE;
            shake_left  <= 8'(SHAKE_CYCLES - 1);
            busy        <= 1'b1;
            score_valid <= 1'b0;
          end
`ifdef YACHT_DICE_FORCE_EN
          else if (force_load) begin
            for (int i = 0; i < NUM_DICE; i++)
              dice[DIE_W*i +: DIE_W] <= clean_face(force_dice[DIE_W*i +: DIE_W]);
            state       <= ST_COUNT;
            count_k     <= 3'd0;
            cnt         <= '0;
            sum         <= 5'd0;
            busy        <= 1'b1;
            score_valid <= 1'b0;
          end
`endif
          // Rescore the settled histogram when the category moves.
          else if (rolled && category_idx != cat_reg) begin
            state       <= ST_EVAL;
            score_valid <= 1'b0;
          end
        end
        ST_SHAKE: begin
          for (int i = 0; i < NUM_DICE; i++)
            if (!hold_mask[i]) dice[DIE_W*i +: DIE_W] <= draw_die(rnd[5*i +: 8]);
          if (shake_left == 8'd0) begin
            state   <= ST_COUNT;
            count_k <= 3'd0;
            cnt     <= '0;
            sum     <= 5'd0;
          end else begin
            shake_left <= shake_left - 8'd1;
          end
        end
        ST_COUNT: begin
          cnt[cur_die] <= cnt[cur_die] + 3'd1;
          sum          <= sum + 5'(cur_die);
          if (count_k == 3'(NUM_DICE - 1)) state   <= ST_EVAL;
          else                             count_k <= count_k + 3'd1;
        end
        ST_EVAL: begin
          calc_score  <= score_of(category_idx, cnt, sum);
          cat_reg     <= category_idx;
          busy        <= 1'b0;
          score_valid <= 1'b1;
          rolled      <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
